dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dlx_mem_pkg.sv | 18 +
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_ctrl.sv | 125 ++++++++++++
 tb/tb_dmem_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared types and default parameters for the DLX data-memory controller.
package dlx_mem_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned AW_DEF        = 8;
    localparam int unsigned READ_LAT_DEF  = 2;
    localparam int unsigned WRITE_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2,
        WR_WAIT = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write port, asynchronous read port, contents never reset.
module dmem_array
    import dlx_mem_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: latency-programmable load/store sequencing over dmem_array
// with a once-per-assertion store guard and a combinational data-valid qualifier.
module dmem_ctrl
    import dlx_mem_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned READ_LAT  = READ_LAT_DEF,
    parameter int unsigned WRITE_LAT = WRITE_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_data_write,
    input  logic              d_write_enable,
    output logic              d_data_valid,
    output logic [DATA_W-1:0] d_data_read
);

    localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WRITE_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    dmem_state_e       state;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              wr_seen;

    logic [AW-1:0]     idx_c;
    logic              wr_elig_c;
    logic              cnt_last_c;
    logic              arr_we_c;
    logic [DATA_W-1:0] arr_rdata_c;
    logic              unused_addr_c;

    // Byte offset and bits above the array span alias onto the same word.
    assign idx_c         = d_address[AW+1:2];
    assign unused_addr_c = ^{d_address[ADDR_W-1:AW+2], d_address[1:0]};

    assign wr_elig_c  = d_write_enable && !wr_seen;
    assign cnt_last_c = (cnt == CNT_ONE);
    assign arr_we_c   = (state == WR_WAIT) && cnt_last_c;

    assign d_data_valid = (state == RD_DONE) && (idx_c == idx_q)
                          && (!d_write_enable || wr_seen);

    dmem_array #(
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_c),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (arr_rdata_c)
    );

    // Sequencer: accepts one operation, counts down its latency, then captures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx_q       <= '0;
            wdata_q     <= '0;
            cnt         <= CNT_ZERO;
            wr_seen     <= 1'b0;
            d_data_read <= '0;
        end else begin
            if (!d_write_enable) begin
                wr_seen <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    idx_q <= idx_c;
                    if (wr_elig_c) begin
                        wdata_q <= d_data_write;
                        cnt     <= WR_CNT;
                        state   <= WR_WAIT;
                    end else begin
                        cnt     <= RD_CNT;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_last_c) begin
                        d_data_read <= arr_rdata_c;
                        cnt         <= CNT_ZERO;
                        state       <= RD_DONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_WAIT: begin
                    if (cnt_last_c) begin
                        d_data_read <= wdata_q;
                        cnt         <= CNT_ZERO;
                        state       <= RD_DONE;
                        // A store already released by the core must not block the next one.
                        if (d_write_enable) begin
                            wr_seen <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RD_DONE: begin
                    if (wr_elig_c) begin
                        idx_q   <= idx_c;
                        wdata_q <= d_data_write;
                        cnt     <= WR_CNT;
                        state   <= WR_WAIT;
                    end else if (idx_c != idx_q) begin
                        idx_q <= idx_c;
                        cnt   <= RD_CNT;
                        state <= RD_WAIT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed vector bench for dmem_ctrl: default-latency instance driven from a table,
// plus a WRITE_LAT=3 instance for reset abort during a pending store.
module tb_dmem_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic        d_write_enable;
    logic        d_data_valid;
    logic [31:0] d_data_read;

    logic        r3_n;
    logic [31:0] a3;
    logic [31:0] w3;
    logic        we3;
    logic        v3;
    logic [31:0] rd3;

    int unsigned n_cmp;
    int unsigned n_bad;
    vec_t        vecs[$];

    dmem_ctrl u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .d_address      (d_address),
        .d_data_write   (d_data_write),
        .d_write_enable (d_write_enable),
        .d_data_valid   (d_data_valid),
        .d_data_read    (d_data_read)
    );

    dmem_ctrl #(
        .AW        (8),
        .READ_LAT  (2),
        .WRITE_LAT (3)
    ) u_dut3 (
        .clk            (clk),
        .reset_n        (r3_n),
        .d_address      (a3),
        .d_data_write   (w3),
        .d_write_enable (we3),
        .d_data_valid   (v3),
        .d_data_read    (rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                       input logic ev, input logic [31:0] ed);
        vec_t v;
        v.addr = addr;
        v.we   = we;
        v.wd   = wd;
        v.ev   = ev;
        v.ed   = ed;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b1;
        r3_n = 1'b1;
        d_address = '0;
        d_data_write = '0;
        d_write_enable = 1'b0;
        a3 = '0;
        w3 = '0;
        we3 = 1'b0;

        // Held store to 0x10, single execution, valid persists after release.
        for (int i = 0; i < 2; i++) add(32'h10, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) add(32'h10, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) add(32'h10, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        // One-cycle store pulse to 0x14.
        add(32'h14, 1'b1, 32'h01234567, 1'b0, 32'hDEADBEEF);
        add(32'h14, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
        add(32'h14, 1'b0, 32'h0, 1'b1, 32'h01234567);
        // Read back 0x10.
        for (int i = 0; i < 3; i++) add(32'h10, 1'b0, 32'h0, 1'b0, 32'h01234567);
        add(32'h10, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        // Address change in RD_DONE: valid drops at once, new word two edges after acceptance.
        for (int i = 0; i < 3; i++) add(32'h14, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
        add(32'h14, 1'b0, 32'h0, 1'b1, 32'h01234567);
        // Aliased addresses 0x410 and 0x13 hit word 4.
        for (int i = 0; i < 3; i++) add(32'h410, 1'b0, 32'h0, 1'b0, 32'h01234567);
        add(32'h410, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        add(32'h13, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        // Address change while RD_WAIT: latched read completes with valid low.
        for (int i = 0; i < 3; i++) add(32'h14, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
        add(32'h10, 1'b0, 32'h0, 1'b0, 32'h01234567);
        add(32'h14, 1'b0, 32'h0, 1'b0, 32'h01234567);
        add(32'h14, 1'b0, 32'h0, 1'b0, 32'h01234567);
        for (int i = 0; i < 3; i++) add(32'h14, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
        add(32'h14, 1'b0, 32'h0, 1'b1, 32'h01234567);
        // Two stores to 0x20 separated by one idle cycle.
        add(32'h20, 1'b1, 32'h11111111, 1'b0, 32'h01234567);
        add(32'h20, 1'b1, 32'h11111111, 1'b0, 32'h01234567);
        add(32'h20, 1'b1, 32'h11111111, 1'b1, 32'h11111111);
        add(32'h20, 1'b0, 32'h11111111, 1'b1, 32'h11111111);
        add(32'h20, 1'b1, 32'h22222222, 1'b0, 32'h11111111);
        add(32'h20, 1'b1, 32'h22222222, 1'b0, 32'h11111111);
        add(32'h20, 1'b1, 32'h22222222, 1'b1, 32'h22222222);
        add(32'h20, 1'b0, 32'h0, 1'b1, 32'h22222222);
        for (int i = 0; i < 3; i++) add(32'h10, 1'b0, 32'h0, 1'b0, 32'h22222222);
        for (int i = 0; i < 3; i++) add(32'h20, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
        add(32'h20, 1'b0, 32'h0, 1'b1, 32'h22222222);
        // Store completes with WE still held, then address moves: treated as a read.
        add(32'h20, 1'b1, 32'h22222222, 1'b0, 32'h22222222);
        add(32'h20, 1'b1, 32'h22222222, 1'b0, 32'h22222222);
        add(32'h20, 1'b1, 32'h22222222, 1'b1, 32'h22222222);
        for (int i = 0; i < 3; i++) add(32'h10, 1'b1, 32'h99999999, 1'b0, 32'h22222222);
        add(32'h10, 1'b1, 32'h99999999, 1'b1, 32'hDEADBEEF);
        add(32'h10, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);

        #2;
        reset_n = 1'b0;
        r3_n = 1'b0;
        #1;
        chk("rst_valid_async", 32'(d_data_valid), 32'h0);
        chk("rst_data_async", d_data_read, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(d_data_valid), 32'h0);
        chk("rst_data", d_data_read, 32'h0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            d_address      = vecs[i].addr;
            d_write_enable = vecs[i].we;
            d_data_write   = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(d_data_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_data", i), d_data_read, vecs[i].ed);
            @(posedge clk);
            #1;
        end

        // WRITE_LAT=3 instance: establish a prior value at 0x10.
        r3_n = 1'b1;
        a3 = 32'h10;
        w3 = 32'hAAAA5555;
        we3 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("wl3_prior_valid", 32'(v3), 32'h1);
        chk("wl3_prior_data", rd3, 32'hAAAA5555);
        we3 = 1'b0;
        @(posedge clk);
        #1;
        // Second store, reset one edge into its wait.
        w3 = 32'hCAFEF00D;
        we3 = 1'b1;
        @(posedge clk);
        #1;
        chk("wl3_wait_valid", 32'(v3), 32'h0);
        @(posedge clk);
        #1;
        r3_n = 1'b0;
        #1;
        chk("wl3_abort_valid", 32'(v3), 32'h0);
        chk("wl3_abort_data", rd3, 32'h0);
        we3 = 1'b0;
        @(posedge clk);
        #1;
        r3_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("wl3_after_valid", 32'(v3), 32'h1);
        chk("wl3_after_data", rd3, 32'hAAAA5555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
